// File: rtl/mdu_divider_pkg.sv
// Shared ALU select codes and MDU state encoding for the RV32IM execute stage.
// This package is the single source for the ALU_* codes used by the ALU control unit and the MDU.
package mdu_divider_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_MUL    = 5'd10;
    localparam logic [4:0] ALU_MULH   = 5'd11;
    localparam logic [4:0] ALU_MULHSU = 5'd12;
    localparam logic [4:0] ALU_MULHU  = 5'd13;
    localparam logic [4:0] ALU_DIV    = 5'd14;
    localparam logic [4:0] ALU_DIVU   = 5'd15;
    localparam logic [4:0] ALU_REM    = 5'd16;
    localparam logic [4:0] ALU_REMU   = 5'd17;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div_sel(input logic [4:0] sel);
        return (sel == ALU_DIV) || (sel == ALU_DIVU) || (sel == ALU_REM) || (sel == ALU_REMU);
    endfunction

    function automatic logic is_signed_div_sel(input logic [4:0] sel);
        return (sel == ALU_DIV) || (sel == ALU_REM);
    endfunction

    function automatic logic is_rem_sel(input logic [4:0] sel);
        return (sel == ALU_REM) || (sel == ALU_REMU);
    endfunction

endpackage

// File: rtl/mdu_divider_div_restore_step.sv
// One radix-2 restoring division step: shifts {rem, quo} left and subtracts the divisor on success.
module div_restore_step
    import mdu_divider_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_next_o,
    output logic [XLEN-1:0] quo_next_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // The shifted remainder can reach 2*divisor-1, so the trial needs one extra bit.
    always_comb begin
        shifted    = {rem_i, quo_i[XLEN-1]};
        trial      = shifted - {1'b0, divisor_i};
        rem_next_o = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        quo_next_o = {quo_i[XLEN-2:0], ~trial[XLEN]};
    end

endmodule

// File: rtl/mdu_divider.sv
// Multi-cycle RV32IM divide unit (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per cycle.
// Optional last-result cache enabled by defining MDU_DIV_CACHE_EN.
module mdu_divider
    import mdu_divider_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [4:0]      alu_sel_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic [XLEN-1:0] result_o,
    output logic            done_o,
    output logic            busy_o,
    output logic            stall_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  divisor_q, divisor_d;
    logic             negQuo_q, negQuo_d;
    logic             negRem_q, negRem_d;
    logic             isRem_q, isRem_d;

    logic            isDiv, signedOp, accept, cacheHit;
    logic [XLEN-1:0] magA, magB, stepRem, stepQuo, finalQuo, finalRem;
    logic [XLEN-1:0] hitQuo, hitRem;

    assign isDiv    = is_div_sel(alu_sel_i);
    assign signedOp = is_signed_div_sel(alu_sel_i);
    assign accept   = (state_q == MDU_IDLE) && start_i && isDiv && !flush_i;
    assign magA     = (signedOp && op_a_i[XLEN-1]) ? -op_a_i : op_a_i;
    assign magB     = (signedOp && op_b_i[XLEN-1]) ? -op_b_i : op_b_i;
    assign finalQuo = negQuo_q ? -quo_q : quo_q;
    assign finalRem = negRem_q ? -rem_q : rem_q;

    div_restore_step #(.XLEN(XLEN)) u_step (
        .rem_i      (rem_q),
        .quo_i      (quo_q),
        .divisor_i  (divisor_q),
        .rem_next_o (stepRem),
        .quo_next_o (stepQuo)
    );

`ifdef MDU_DIV_CACHE_EN
    logic [XLEN-1:0] opA_q, opB_q, cacheA_q, cacheB_q, cacheQuo_q, cacheRem_q;
    logic            signed_q, cacheSigned_q, cacheValid_q;

    assign cacheHit = cacheValid_q && (op_a_i == cacheA_q) && (op_b_i == cacheB_q)
                      && (signedOp == cacheSigned_q);
    assign hitQuo   = cacheQuo_q;
    assign hitRem   = cacheRem_q;

    // Only a real CALC completion fills the entry; a flushed run leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA_q         <= '0;
            opB_q         <= '0;
            signed_q      <= 1'b0;
            cacheA_q      <= '0;
            cacheB_q      <= '0;
            cacheQuo_q    <= '0;
            cacheRem_q    <= '0;
            cacheSigned_q <= 1'b0;
            cacheValid_q  <= 1'b0;
        end else begin
            if (accept) begin
                opA_q    <= op_a_i;
                opB_q    <= op_b_i;
                signed_q <= signedOp;
            end
            if ((state_q == MDU_CALC) && (cnt_q == '0) && !flush_i) begin
                cacheA_q      <= opA_q;
                cacheB_q      <= opB_q;
                cacheSigned_q <= signed_q;
                cacheQuo_q    <= negQuo_q ? -stepQuo : stepQuo;
                cacheRem_q    <= negRem_q ? -stepRem : stepRem;
                cacheValid_q  <= 1'b1;
            end
        end
    end
`else
    assign cacheHit = 1'b0;
    assign hitQuo   = '0;
    assign hitRem   = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            negQuo_q  <= 1'b0;
            negRem_q  <= 1'b0;
            isRem_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            negQuo_q  <= negQuo_d;
            negRem_q  <= negRem_d;
            isRem_q   <= isRem_d;
        end
    end

    // Special cases and cache hits load final values with sign fix-up disabled.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        negQuo_d  = negQuo_q;
        negRem_d  = negRem_q;
        isRem_d   = isRem_q;
        case (state_q)
            MDU_IDLE: begin
                if (accept) begin
                    isRem_d   = is_rem_sel(alu_sel_i);
                    divisor_d = magB;
                    negQuo_d  = 1'b0;
                    negRem_d  = 1'b0;
                    state_d   = MDU_DONE;
                    if (op_b_i == '0) begin
                        quo_d = '1;
                        rem_d = op_a_i;
                    end else if (signedOp && (op_a_i == INT_MIN) && (op_b_i == '1)) begin
                        quo_d = INT_MIN;
                        rem_d = '0;
                    end else if (cacheHit) begin
                        quo_d = hitQuo;
                        rem_d = hitRem;
                    end else begin
                        state_d  = MDU_CALC;
                        cnt_d    = CNT_W'(XLEN - 1);
                        rem_d    = '0;
                        quo_d    = magA;
                        negQuo_d = signedOp && (op_a_i[XLEN-1] ^ op_b_i[XLEN-1]);
                        negRem_d = signedOp && op_a_i[XLEN-1];
                    end
                end
            end
            MDU_CALC: begin
                rem_d = stepRem;
                quo_d = stepQuo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = MDU_DONE;
                end
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
        if (flush_i) begin
            state_d = MDU_IDLE;
        end
    end

    assign done_o   = (state_q == MDU_DONE) && !flush_i;
    assign result_o = done_o ? (isRem_q ? finalRem : finalQuo) : '0;
    assign busy_o   = (state_q == MDU_CALC);
    assign stall_o  = ((state_q == MDU_IDLE) && start_i && isDiv) || (state_q == MDU_CALC);

endmodule

// File: doc/mdu_divider.md
# mdu_divider

Multi-cycle integer divide unit for the RV32IM execute stage, directly downstream of the ALU control unit. It consumes the 5-bit ALU select code and executes only `ALU_DIV`, `ALU_DIVU`, `ALU_REM` and `ALU_REMU`, using a radix-2 restoring algorithm (one quotient bit per cycle). It stalls the pipeline while it runs and presents a one-cycle `done_o` strobe with the architecturally correct result, including the RISC-V divide-by-zero and signed-overflow cases. All other select codes pass through untouched; the single-cycle ALU handles them.

## Interface
- `XLEN`, 32: operand and result width. The iteration counter is clog2(XLEN) bits wide.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  the EX-stage instruction is valid this cycle.
- `flush_i`  in  1  synchronous abort from the hazard/branch unit.
- `alu_sel_i`  in  5  select code from the ALU control unit (`ALU_*` encoding).
- `op_a_i`  in  XLEN  dividend (rs1, after forwarding).
- `op_b_i`  in  XLEN  divisor (rs2, after forwarding).
- `result_o`  out  XLEN  quotient or remainder. Valid only while `done_o`=1.
- `done_o`  out  1  result-valid strobe, high for one cycle.
- `busy_o`  out  1  high while iterating.
- `stall_o`  out  1  combinational stall request to the IF/ID/EX pipeline registers.

## Operation
- `is_div` = (`alu_sel_i` ∈ {`ALU_DIV`, `ALU_DIVU`, `ALU_REM`, `ALU_REMU`}). `signed_op` = DIV or REM.
- States: IDLE, CALC, DONE.
- **IDLE**
  - The unit accepts when `start_i` && `is_div` && !`flush_i`.
  - On acceptance it latches the op kind and the magnitudes |a| and |b|. For signed ops, magnitudes are two's-complement negations when the MSB is set.
  - It also latches the sign of the quotient (a[31]^b[31]) and the sign of the remainder (a[31]).
  - Fast path, to DONE directly:
    - divisor == 0: quotient = all ones, remainder = a.
    - signed op with a = 0x80000000 and b = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
  - Otherwise the unit goes to CALC with counter = XLEN−1, remainder register = 0, quotient register = |a|.
- **CALC**
  - Each cycle: shift {rem, quo} left by 1; trial = rem − |b| (XLEN+1 bits); if trial ≥ 0, rem = trial and quo[0] = 1.
  - At counter = 0 the unit goes to DONE.
- **DONE**
  - Quotient is negated if its sign bit is set; remainder is negated if its sign bit is set. Unsigned ops are never negated.
  - `result_o` = quotient for DIV/DIVU, remainder for REM/REMU. `done_o` = 1.
  - Next state is IDLE unconditionally. `start_i` is ignored in DONE, because the pipeline advances on this edge.
- `stall_o` = (IDLE && `start_i` && `is_div`) || CALC. It is low in DONE.
- `busy_o` = CALC.
- Flush in any state: next state is IDLE, `done_o` stays low, and the partial result is discarded.
- Async reset: state = IDLE; `result_o`, `done_o`, `busy_o` = 0; all datapath registers = 0.

## Timing
- Acceptance edge = edge 0.
  - Normal path: CALC spans cycles 1–32; `done_o` is high in cycle 33. Latency is 33 cycles.
  - Fast path: `done_o` is high in cycle 1.
- Back-to-back divides: the second is accepted at the earliest one cycle after DONE (IDLE re-entry).
- `flush_i` has priority over `start_i` and over completion in the same cycle.
- Reset asserted mid-CALC: all outputs go to 0 immediately; no `done_o` follows.

## Configuration
- `MDU_DIV_CACHE_EN` defined:
  - The unit keeps the last completed {a, b, signed_op, quotient, remainder} and a valid bit.
  - An accepted op whose a, b and signedness match a valid entry goes IDLE→DONE. Latency is 1, which makes the DIV+REM pair cheap.
  - Each completed CALC updates the entry. Reset clears the valid bit. Flush does not clear the valid bit.
- `MDU_DIV_CACHE_EN` undefined: no cache storage; every non-special op takes 33 cycles.

## Structure
- The shared defines file already holds the `ALU_*` select codes and must stay the single source for them. The MDU state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2) is also added there.
- One combinational sub-module, `div_restore_step`: inputs {rem, quo, divisor}, outputs {rem_next, quo_next}. It is instantiated once per CALC cycle.

## Test plan
- DIV 100/7 → `stall_o` high during cycles 0–32, `done_o` in cycle 33, result 14. REM 100/7 → 2.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF. REMU 0xFFFFFFFF/2 → 1.
- DIV 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. Both in cycle 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, both in cycle 1.
- `flush_i` in cycle 10 of DIV 100/7 → `busy_o` low in cycle 11, no `done_o`. A following DIV 9/3 → 3 after the full 33 cycles.
- `rst_n` low in cycle 15 of a DIVU → all outputs 0 immediately, state IDLE. After release, a fresh DIVU 20/4 → 5 in cycle 33.
- DIV 100/7 then REM 100/7 → second result 2 in cycle 1 with `MDU_DIV_CACHE_EN` defined, in cycle 33 without. Also with the macro defined, REMU 100/7 (different signedness) → cache miss, 33 cycles.
